adder_flit_injector: RTL and testbench
======================================

Name: adder_flit_injector

Overview:
- Synthesizable packet/flit stimulus source that sits directly upstream of the `adder` block.
- Emits packets of PAYLOAD flits, each a 2N-bit thermometer-coded word split into the adder's two N-bit operands. Each packet is followed by GAP idle cycles, which sets link utilization PAYLOAD/(PAYLOAD+GAP).
- Replaces bench-side task injection for on-chip and gate-level energy characterization runs.

Parameters:
- N, 11, operand width; flit word width W = 2N.
- PAYLOAD, 20, flits per packet; legal range ≥1.
- GAP, 7, idle cycles after every packet, including the last one; legal range ≥0.
- NUM_PKTS, 10, packets per run; legal range ≥1.
- STRIDE, 6, thermometer fill increment per flit; legal range 1..W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- stall  in  1  downstream hold; freezes flit progress while high in SEND.
- input1  out  N  adder operand A = word[N-1:0]; registered.
- input2  out  N  adder operand B = word[2N-1:N]; registered.
- flit_valid  out  1  high while a payload flit is presented.
- last_flit  out  1  high with the final flit of each packet.
- pkt_idx  out  clog2(NUM_PKTS+1)  index of the current packet, 0-based.
- busy  out  1  high in SEND or GAP.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset: state=IDLE. input1, input2, flit_valid, last_flit, pkt_idx, busy, done all 0. Fill k=0, polarity pol=0, internal counters 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states are IDLE, SEND, GAP.
- IDLE:
  - start=1 → SEND; the first flit appears on the outputs in the next cycle, i.e. 1-cycle latency from start.
  - start while busy is ignored.
- Word generation:
  - At the first flit of every packet, k=0 and pol=0.
  - Each flit: k' = k+STRIDE. If k' > W then k' = k'-(W+1) and pol toggles.
  - pol=0: word = top k' bits set. pol=1: word = bottom k' bits set. k'=0 gives word 0; k'=W gives all ones.
- SEND:
  - One flit per cycle, flit_valid=1.
  - While stall=1: operands, flit_valid, k, pol and the flit counter all hold; the flit counts once.
  - After flit PAYLOAD has been presented (with stall=0): GAP>0 → GAP; GAP=0 → next packet's SEND back-to-back, or end of run if this was the last packet.
- GAP:
  - flit_valid=0, last_flit=0.
  - input1/input2 hold the last flit's value, so there is no toggling during idle.
  - Counts GAP cycles; stall is ignored.
  - At the end: pkt_idx+1. If packets sent = NUM_PKTS → done=1 for one cycle, busy=0, return to IDLE. Otherwise → SEND.
- End of run: pkt_idx resets to 0 together with the done pulse. Operands keep their last value in IDLE.
- rst asserted mid-run: the next edge restores full reset state, and no done pulse is produced.
- Run length with no stall: 1 + NUM_PKTS×(PAYLOAD+GAP) cycles from the start edge to the done edge.

Optional Feature:
- Macro: ADDER_INJ_STATS_EN.
- When defined, adds output ports flit_cnt[31:0] and cycle_cnt[31:0]:
  - flit_cnt counts accepted flits (flit_valid & ~stall).
  - cycle_cnt counts busy cycles.
  - Both clear on rst and on an accepted start, and hold after done for readout.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults, pulse start, no stall → flit 1: input2=0x7E0, input1=0x000. Flit 2: 0x7FF/0x400. Flit 3: 0x7FF/0x7F0. Flit 4 (wrap, pol=1, k=1): input2=0x000, input1=0x001.
- Defaults, full run → 20 flit_valid cycles, then 7 idle cycles with operands held, repeated ×10. last_flit on each 20th flit. done pulses exactly 271 cycles after start. pkt_idx steps 0..9 and then returns to 0.
- stall high for 3 cycles during flit 5 → flit 5 held 4 cycles, no k advance, packet length 23 cycles, done delayed by 3.
- GAP=0, NUM_PKTS=2, PAYLOAD=4 → 8 consecutive flit_valid cycles; the first flit of packet 2 restarts at k=6 (0x7E0/0x000).
- rst asserted during the GAP of packet 3, then start again → all outputs 0 after the reset edge, no done pulse; the new run begins at pkt_idx=0, flit 1.
- With ADDER_INJ_STATS_EN, defaults, no stall → after done, flit_cnt=200 and cycle_cnt=270. A start pulse while busy is ignored and does not perturb either count.

Source files
------------

// File: rtl/adder_flit_injector.sv
// Packetised thermometer-code flit source driving the adder's two N-bit operands.
// Build macro ADDER_INJ_STATS_EN adds the flit_cnt / cycle_cnt readout ports.
module adder_flit_injector #(
    parameter int N        = 11,
    parameter int PAYLOAD  = 20,
    parameter int GAP      = 7,
    parameter int NUM_PKTS = 10,
    parameter int STRIDE   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stall,
    output logic [N-1:0]                  input1,
    output logic [N-1:0]                  input2,
    output logic                          flit_valid,
    output logic                          last_flit,
    output logic [$clog2(NUM_PKTS+1)-1:0] pkt_idx,
    output logic                          busy,
`ifdef ADDER_INJ_STATS_EN
    output logic [31:0]                   flit_cnt,
    output logic [31:0]                   cycle_cnt,
`endif
    output logic                          done
);

    localparam int W  = 2 * N;
    localparam int PW = $clog2(NUM_PKTS + 1);
    localparam int CW = $clog2(PAYLOAD + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int KW = $clog2(2 * W + 1);

    localparam logic [CW-1:0] PAYLOAD_C = CW'(PAYLOAD);
    localparam logic [PW-1:0] LAST_PKT  = PW'(NUM_PKTS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [KW-1:0] STRIDE_K  = KW'(STRIDE);
    localparam logic [KW-1:0] W_K       = KW'(W);
    localparam logic [KW-1:0] WRAP_K    = KW'(W + 1);
    localparam logic [W-1:0]  ONES      = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [KW-1:0]  k_q, k_d;
    logic           pol_q, pol_d;
    logic [PW-1:0]  pkt_d;
    logic [W-1:0]   word_d;
    logic           valid_d, last_d, busy_d, done_d;

    logic           load, first, pkt_end;
    logic [KW-1:0]  k_base, k_sum;
    logic           pol_base;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        k_d      = k_q;
        pol_d    = pol_q;
        pkt_d    = pkt_idx;
        word_d   = {input2, input1};
        valid_d  = flit_valid;
        last_d   = last_flit;
        busy_d   = busy;
        done_d   = 1'b0;
        load     = 1'b0;
        first    = 1'b0;
        pkt_end  = 1'b0;
        k_base   = '0;
        pol_base = 1'b0;
        k_sum    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                    pkt_d   = '0;
                end
            end
            S_SEND: begin
                if (!stall) begin
                    if (cnt_q != PAYLOAD_C) begin
                        load  = 1'b1;
                        first = (cnt_q == '0);
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        pkt_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    pkt_end = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The edge that closes a packet either finishes the run or launches the next packet's first flit.
        if (pkt_end) begin
            if (pkt_idx == LAST_PKT) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                pkt_d   = '0;
            end else begin
                state_d = S_SEND;
                pkt_d   = pkt_idx + 1'b1;
                load    = 1'b1;
                first   = 1'b1;
            end
        end

        if (load) begin
            cnt_d    = first ? CW'(1) : cnt_q + 1'b1;
            k_base   = first ? '0 : k_q;
            pol_base = first ? 1'b0 : pol_q;
            k_sum    = k_base + STRIDE_K;
            if (k_sum > W_K) begin
                k_d   = k_sum - WRAP_K;
                pol_d = ~pol_base;
            end else begin
                k_d   = k_sum;
                pol_d = pol_base;
            end
            // pol=0 fills from the MSB down, pol=1 from the LSB up.
            word_d  = pol_d ? ~(ONES << k_d) : ~(ONES >> k_d);
            valid_d = 1'b1;
            last_d  = (cnt_d == PAYLOAD_C);
            busy_d  = 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            k_q        <= '0;
            pol_q      <= 1'b0;
            pkt_idx    <= '0;
            input1     <= '0;
            input2     <= '0;
            flit_valid <= 1'b0;
            last_flit  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            k_q        <= k_d;
            pol_q      <= pol_d;
            pkt_idx    <= pkt_d;
            input1     <= word_d[N-1:0];
            input2     <= word_d[W-1:N];
            flit_valid <= valid_d;
            last_flit  <= last_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef ADDER_INJ_STATS_EN
    // Counters clear on an accepted start and freeze once busy drops, so they stay readable after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt  <= '0;
            cycle_cnt <= '0;
        end else if (state_q == S_IDLE && start) begin
            flit_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (flit_valid && !stall) begin
                flit_cnt <= flit_cnt + 32'd1;
            end
            if (busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_flit_injector.sv
// Scoreboard bench for adder_flit_injector: default instance plus a PAYLOAD=4/GAP=0/NUM_PKTS=2 instance.
`timescale 1ns/1ps
module tb_adder_flit_injector;

    localparam int N         = 11;
    localparam int W         = 2 * N;
    localparam int STRIDE    = 6;
    localparam int PAYLOAD_A = 20;
    localparam int GAP_A     = 7;
    localparam int NPK_A     = 10;
    localparam int PAYLOAD_B = 4;
    localparam int NPK_B     = 2;
    localparam int PW_A      = $clog2(NPK_A + 1);
    localparam int PW_B      = $clog2(NPK_B + 1);

    logic            clk;
    logic            rst, start, stall;
    logic [N-1:0]    input1, input2;
    logic            flit_valid, last_flit, busy, done;
    logic [PW_A-1:0] pkt_idx;

    logic            rst_b, start_b, stall_b;
    logic [N-1:0]    input1_b, input2_b;
    logic            flit_valid_b, last_flit_b, busy_b, done_b;
    logic [PW_B-1:0] pkt_idx_b;

`ifdef ADDER_INJ_STATS_EN
    logic [31:0] flit_cnt, cycle_cnt, flit_cnt_b, cycle_cnt_b;
`endif

    adder_flit_injector dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .input1(input1), .input2(input2), .flit_valid(flit_valid), .last_flit(last_flit),
        .pkt_idx(pkt_idx), .busy(busy),
`ifdef ADDER_INJ_STATS_EN
        .flit_cnt(flit_cnt), .cycle_cnt(cycle_cnt),
`endif
        .done(done)
    );

    adder_flit_injector #(.PAYLOAD(PAYLOAD_B), .GAP(0), .NUM_PKTS(NPK_B)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stall(stall_b),
        .input1(input1_b), .input2(input2_b), .flit_valid(flit_valid_b), .last_flit(last_flit_b),
        .pkt_idx(pkt_idx_b), .busy(busy_b),
`ifdef ADDER_INJ_STATS_EN
        .flit_cnt(flit_cnt_b), .cycle_cnt(cycle_cnt_b),
`endif
        .done(done_b)
    );

    typedef struct {
        logic [N-1:0] in1;
        logic [N-1:0] in2;
        logic         last;
        int           pkt;
        int           idx;
    } flit_t;

    flit_t sb[$];
    int    vectors;
    int    miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: walk the fill sequence and set each bit by position.
    function automatic logic [W-1:0] model_word(input int j);
        int k;
        bit pol;
        logic [W-1:0] w;
        k   = 0;
        pol = 1'b0;
        for (int i = 0; i < j; i++) begin
            k += STRIDE;
            if (k > W) begin
                k -= W + 1;
                pol = ~pol;
            end
        end
        for (int b = 0; b < W; b++) begin
            w[b] = pol ? (b < k) : (b >= W - k);
        end
        return w;
    endfunction

    task automatic push_run(input int payload, input int npkts);
        logic [W-1:0] w;
        flit_t f;
        for (int p = 0; p < npkts; p++) begin
            for (int j = 1; j <= payload; j++) begin
                w      = model_word(j);
                f.in1  = w[N-1:0];
                f.in2  = w[W-1:N];
                f.last = (j == payload);
                f.pkt  = p;
                f.idx  = j;
                sb.push_back(f);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        start = 1'b0; start_b = 1'b0;
        stall = 1'b0; stall_b = 1'b0;
        tick();
        tick();
        vectors++;
        if ({input1, input2, flit_valid, last_flit, pkt_idx, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got in1=%h in2=%h v=%b l=%b pkt=%0d busy=%b done=%b, want all 0",
                     input1, input2, flit_valid, last_flit, pkt_idx, busy, done);
        end
        vectors++;
        if ({input1_b, input2_b, flit_valid_b, last_flit_b, pkt_idx_b, busy_b, done_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got in1=%h in2=%h v=%b l=%b pkt=%0d busy=%b done=%b, want all 0",
                     input1_b, input2_b, flit_valid_b, last_flit_b, pkt_idx_b, busy_b, done_b);
        end
`ifdef ADDER_INJ_STATS_EN
        vectors++;
        if ({flit_cnt, cycle_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_stats: got flit_cnt=%0d cycle_cnt=%0d, want 0/0", flit_cnt, cycle_cnt);
        end
`endif
        rst = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_first_flits();
        logic [N-1:0] e2 [4];
        logic [N-1:0] e1 [4];
        e2 = '{11'h7E0, 11'h7FF, 11'h7FF, 11'h000};
        e1 = '{11'h000, 11'h400, 11'h7F0, 11'h001};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({flit_valid, input2, input1} !== {1'b1, e2[i], e1[i]}) begin
                miscompares++;
                $display("FAIL first_flit%0d: got v=%b in2=%h in1=%h, want v=1 in2=%h in1=%h",
                         i + 1, flit_valid, input2, input1, e2[i], e1[i]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Runs one full default-instance packet run against the scoreboard.
    task automatic run_a(input int stall_flit, input bit gap_stall, input int spurious_at,
                         input int exp_done, input int exp_pkt0_len);
        int c, flits, pkt0_len, idle_run, stall_left;
        bit hold, got_done;
        flit_t exp;
        logic [N-1:0] held1, held2;
        c = 0; flits = 0; pkt0_len = 0; idle_run = 0; stall_left = 0;
        hold = 1'b0; got_done = 1'b0;
        held1 = '0; held2 = '0;
        exp.in1 = '0; exp.in2 = '0; exp.last = 1'b0; exp.pkt = -1; exp.idx = 0;
        sb.delete();
        push_run(PAYLOAD_A, NPK_A);
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (flit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency: flit_valid=%b on the start edge, want 0", flit_valid);
        end
        while (!got_done && c < exp_done + 40) begin
            tick();
            c++;
            if (flit_valid === 1'b1) begin
                if (!hold) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_flit: cycle %0d flit with empty scoreboard", c);
                    end else begin
                        exp = sb.pop_front();
                    end
                end
                if (idle_run != 0) begin
                    vectors++;
                    if (idle_run != GAP_A) begin
                        miscompares++;
                        $display("FAIL gap_len: got %0d idle cycles, want %0d", idle_run, GAP_A);
                    end
                    idle_run = 0;
                end
                vectors++;
                if ({input2, input1, last_flit} !== {exp.in2, exp.in1, exp.last} ||
                    pkt_idx !== PW_A'(exp.pkt)) begin
                    miscompares++;
                    $display("FAIL flit p%0d f%0d: got in2=%h in1=%h last=%b pkt=%0d, want in2=%h in1=%h last=%b pkt=%0d",
                             exp.pkt, exp.idx, input2, input1, last_flit, pkt_idx,
                             exp.in2, exp.in1, exp.last, exp.pkt);
                end
                flits++;
                if (exp.pkt == 0) pkt0_len++;
                held1 = exp.in1;
                held2 = exp.in2;
                if (!hold && exp.pkt == 0 && exp.idx == stall_flit) stall_left = 3;
            end else if (done === 1'b1) begin
                got_done = 1'b1;
                vectors++;
                if (c != exp_done) begin
                    miscompares++;
                    $display("FAIL done_cycle: got %0d, want %0d", c, exp_done);
                end
                vectors++;
                if ({busy, pkt_idx, last_flit} !== '0 || idle_run != GAP_A) begin
                    miscompares++;
                    $display("FAIL done_state: got busy=%b pkt=%0d last=%b final_gap=%0d, want 0/0/0/%0d",
                             busy, pkt_idx, last_flit, idle_run, GAP_A);
                end
                vectors++;
                if ({input2, input1} !== {held2, held1}) begin
                    miscompares++;
                    $display("FAIL idle_hold: got %h/%h, want %h/%h", input2, input1, held2, held1);
                end
            end else if (busy === 1'b1) begin
                idle_run++;
                vectors++;
                if ({input2, input1} !== {held2, held1} || last_flit !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_hold: cycle %0d got %h/%h last=%b, want %h/%h last=0",
                             c, input2, input1, last_flit, held2, held1);
                end
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL busy_drop: cycle %0d busy=0 without done", c);
            end
            start = (c == spurious_at);
            stall = 1'b0;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else if (gap_stall && busy === 1'b1 && flit_valid !== 1'b1) begin
                stall = 1'b1;
            end
            hold = (flit_valid === 1'b1) && stall;
        end
        start = 1'b0;
        stall = 1'b0;
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", exp_done + 40);
        end
        vectors++;
        if (flits != exp_pkt0_len + PAYLOAD_A * (NPK_A - 1)) begin
            miscompares++;
            $display("FAIL valid_cycles: got %0d, want %0d", flits, exp_pkt0_len + PAYLOAD_A * (NPK_A - 1));
        end
        vectors++;
        if (pkt0_len != exp_pkt0_len) begin
            miscompares++;
            $display("FAIL pkt0_len: got %0d, want %0d", pkt0_len, exp_pkt0_len);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_flits: %0d expected flits never seen", sb.size());
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: cycle after done got done=%b busy=%b, want 0/0", done, busy);
        end
`ifdef ADDER_INJ_STATS_EN
        vectors++;
        if (flit_cnt !== 32'd200 || cycle_cnt !== 32'(exp_done - 1)) begin
            miscompares++;
            $display("FAIL stats: got flit_cnt=%0d cycle_cnt=%0d, want 200/%0d", flit_cnt, cycle_cnt, exp_done - 1);
        end
`endif
    endtask

    task automatic test_full_run();
        run_a(0, 1'b0, 50, 1 + NPK_A * (PAYLOAD_A + GAP_A), PAYLOAD_A);
    endtask

    task automatic test_stall();
        run_a(5, 1'b1, -1, 1 + NPK_A * (PAYLOAD_A + GAP_A) + 3, PAYLOAD_A + 3);
    endtask

    task automatic test_back_to_back();
        int c, run;
        bit got_done;
        flit_t exp;
        c = 0; run = 0; got_done = 1'b0;
        exp.in1 = '0; exp.in2 = '0; exp.last = 1'b0; exp.pkt = -1; exp.idx = 0;
        sb.delete();
        push_run(PAYLOAD_B, NPK_B);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (!got_done && c < 40) begin
            tick();
            c++;
            if (flit_valid_b === 1'b1) begin
                run++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra: cycle %0d flit with empty scoreboard", c);
                end else begin
                    exp = sb.pop_front();
                    if ({input2_b, input1_b, last_flit_b} !== {exp.in2, exp.in1, exp.last} ||
                        pkt_idx_b !== PW_B'(exp.pkt)) begin
                        miscompares++;
                        $display("FAIL b2b_flit p%0d f%0d: got in2=%h in1=%h last=%b pkt=%0d, want in2=%h in1=%h last=%b pkt=%0d",
                                 exp.pkt, exp.idx, input2_b, input1_b, last_flit_b, pkt_idx_b,
                                 exp.in2, exp.in1, exp.last, exp.pkt);
                    end
                    if (exp.pkt == 1 && exp.idx == 1) begin
                        vectors++;
                        if ({input2_b, input1_b} !== {11'h7E0, 11'h000}) begin
                            miscompares++;
                            $display("FAIL b2b_restart: got %h/%h, want 7e0/000", input2_b, input1_b);
                        end
                    end
                end
            end else if (done_b === 1'b1) begin
                got_done = 1'b1;
                vectors++;
                if (c != 1 + NPK_B * PAYLOAD_B || run != NPK_B * PAYLOAD_B) begin
                    miscompares++;
                    $display("FAIL b2b_done: got done at %0d after %0d-flit burst, want %0d and %0d",
                             c, run, 1 + NPK_B * PAYLOAD_B, NPK_B * PAYLOAD_B);
                end
            end else begin
                run = 0;
            end
        end
        vectors++;
        if (!got_done || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_end: got done=%b leftover=%0d, want done and 0 left", got_done, sb.size());
        end
    endtask

    task automatic test_reset_midrun();
        bit found, saw_done;
        found = 1'b0;
        saw_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (pkt_idx == 2 && busy === 1'b1 && flit_valid === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midrun_gap: never reached gap of packet 3");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({input1, input2, flit_valid, last_flit, pkt_idx, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got in1=%h in2=%h v=%b l=%b pkt=%0d busy=%b done=%b, want all 0",
                     input1, input2, flit_valid, last_flit, pkt_idx, busy, done);
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL midrun_ghost: got done/busy after reset, want neither");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if ({flit_valid, pkt_idx, input2, input1} !== {1'b1, PW_A'(0), 11'h7E0, 11'h000}) begin
            miscompares++;
            $display("FAIL midrun_restart: got v=%b pkt=%0d in2=%h in1=%h, want v=1 pkt=0 in2=7e0 in1=000",
                     flit_valid, pkt_idx, input2, input1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_flits();
        test_full_run();
        test_stall();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
